// File: rtl/arb_pkg.sv
// Purpose: shared types and constants for the four-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: arbiter state enum, requester count, owner index width and a
// wrap-around index increment helper.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Next requester index in round-robin order; 3 wraps to 0 naturally
  // because the index is exactly IDX_W bits wide.
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/decoder2x4.sv
// Purpose: binary index to one-hot decoder (2-bit index, 4 outputs).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
//
// Ports:
//   idx     in  [IDX_W-1:0]   binary index
//   onehot  out [NUM_REQ-1:0] bit idx set, all others clear
module decoder2x4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Purpose: four-requester round-robin arbiter with a bounded hold time.
// Latency: request sampled on edge N is granted from edge N (registered grant).
// Backpressure: requests are level-sensitive and never latched; the owner keeps
//               the grant while it holds req, until MAX_HOLD forces rotation.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [3:0] request vector, bit i = requester i
//   gnt        out  [3:0] one-hot grant, zero when nobody owns the resource
//   gnt_idx    out  [1:0] current owner index, meaningful only with gnt_valid
//   gnt_valid  out  high while some requester owns the resource
//   preempt    out  one-cycle pulse after a hold-limit forced hand-off
//
// MAX_HOLD = 0 disables the hold limit. HOLD_W must satisfy 2**HOLD_W > MAX_HOLD.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               preempt
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  // With no limit the counter simply parks at its maximum value.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_LIM;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] other_req;
  logic [IDX_W-1:0]   owner_next;
  logic               hold_at_limit;

  // First requester with its bit set, scanning start, start+1, ... mod 4.
  // Walking the offsets downward lets the smallest offset win last.
  // Callers only use the result when r is non-zero.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel;
    sel = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (r[idx]) begin
        sel = idx;
      end
    end
    return sel;
  endfunction

  decoder2x4 u_dec (
    .idx    (owner_q),
    .onehot (owner_onehot)
  );

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = owner_q;
  assign gnt       = owner_onehot & {NUM_REQ{gnt_valid}};
  assign preempt   = preempt_q;

  // Requests from everyone except the current owner; used both for the
  // no-bubble hand-off on release and for the forced hand-off.
  assign other_req     = req & ~owner_onehot;
  assign owner_next    = idx_inc(owner_q);
  assign hold_at_limit = (MAX_HOLD != 0) && (hold_q >= HOLD_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = pick(req, ptr_q);
          state_d = GRANT;
          hold_d  = HOLD_W'(1);
        end
      end

      GRANT: begin
        if (!req[owner_q]) begin
          // Release wins over the hold limit, so no preempt pulse here.
          ptr_d = owner_next;
          if (|other_req) begin
            owner_d = pick(other_req, owner_next);
            hold_d  = HOLD_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else if (hold_at_limit && (|other_req)) begin
          owner_d   = pick(other_req, owner_next);
          ptr_d     = owner_next;
          hold_d    = HOLD_W'(1);
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Purpose: self-checking bench for rr_arbiter4 (directed cases + random traffic).
// Latency: expects grants registered on the edge that samples the request.
// Backpressure: n/a; the bench drives req freely and checks every cycle.
module tb_rr_arbiter4;

  localparam int MH        = 8;
  localparam int FAIR_LIM  = 3 * MH + 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks;
  int failures;

  // Behavioural model state: who owns, where the scan starts, how long held.
  int m_own;
  bit m_vld;
  int m_ptr;
  int m_hold;
  bit m_pre;
  int wait_cnt [4];

  rr_arbiter4 #(.MAX_HOLD(MH), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int mpick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own  = 0;
    m_vld  = 0;
    m_ptr  = 0;
    m_hold = 0;
    m_pre  = 0;
  endtask

  task automatic model_update(input logic [3:0] r);
    logic [3:0] others;
    int         old_own;
    m_pre = 0;
    if (!m_vld) begin
      if (r != 4'b0) begin
        m_own  = mpick(r, m_ptr);
        m_vld  = 1;
        m_hold = 1;
      end
    end else begin
      old_own = m_own;
      others  = r;
      others[old_own] = 1'b0;
      if (!r[old_own]) begin
        m_ptr = (old_own + 1) % 4;
        if (others != 4'b0) begin
          m_own  = mpick(others, m_ptr);
          m_hold = 1;
        end else begin
          m_vld = 0;
        end
      end else if (MH != 0 && m_hold >= MH && others != 4'b0) begin
        m_ptr  = (old_own + 1) % 4;
        m_own  = mpick(others, m_ptr);
        m_hold = 1;
        m_pre  = 1;
      end else if (MH != 0) begin
        m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    g = 4'b0;
    if (m_vld) g[m_own] = 1'b1;
    return g;
  endfunction

  // Drive one cycle: req is set mid-cycle, the edge samples it, and the
  // model advances on the same edge. Returns 1 time unit after the edge.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    if (rst_n) model_update(r);
    else       model_reset();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("gnt", gnt, model_gnt());
    chk("gnt_valid", gnt_valid, m_vld);
    chk("preempt", preempt, m_pre);
    if (m_vld) chk("gnt_idx", gnt_idx, m_own[1:0]);
    chk("onehot", ($countones(gnt) <= 1), 1);
    if (!gnt_valid) chk("idle_gnt_zero", gnt, 4'b0);
    for (int i = 0; i < 4; i++) begin
      if (rst_n && req[i] && !gnt[i]) wait_cnt[i]++;
      else                            wait_cnt[i] = 0;
      if (req[i]) chk("fairness", (wait_cnt[i] > FAIR_LIM), 0);
    end
  end

  initial begin
    logic [3:0] r;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    model_reset();
    rst_n = 1'b0;
    req   = 4'b0;

    // Reset state.
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", gnt_valid, 1'b0);
    chk("rst_idx", gnt_idx, 2'b00);
    chk("rst_preempt", preempt, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-grant: move ptr away from 0 first, then reset while owned.
    step(4'b0010);
    chk("pre_rst_g1", gnt, 4'b0010);
    step(4'b0100);                        // release 1 -> ptr=2, grant 2
    chk("pre_rst_g2", gnt, 4'b0100);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_gnt", gnt, 4'b0000);
    chk("midrst_valid", gnt_valid, 1'b0);
    #7;
    rst_n = 1'b1;
    step(4'b1001);                        // ptr back to 0 -> requester 0
    chk("post_rst_gnt", gnt, 4'b0001);

    // Round-robin rotation with each owner dropping after one cycle.
    step(4'b0000);
    begin
      rst_n = 1'b0; model_reset(); #10; rst_n = 1'b1;
    end
    step(4'b1111);
    chk("rot0", gnt, 4'b0001);
    step(4'b1110);
    chk("rot1", gnt, 4'b0010);
    step(4'b1101);
    chk("rot2", gnt, 4'b0100);
    step(4'b1011);
    chk("rot3", gnt, 4'b1000);
    step(4'b0111);
    chk("rot4", gnt, 4'b0001);
    chk("rot4_valid", gnt_valid, 1'b1);

    // Hold-limit preempt with req=0011 held, starting from ptr=0.
    step(4'b0000);
    rst_n = 1'b0; model_reset(); #10; rst_n = 1'b1;
    for (int c = 0; c < MH; c++) begin
      step(4'b0011);
      chk("hold_a_gnt", gnt, 4'b0001);
      chk("hold_a_pre", preempt, 1'b0);
    end
    step(4'b0011);
    chk("preempt_gnt", gnt, 4'b0010);
    chk("preempt_pulse", preempt, 1'b1);
    for (int c = 1; c < MH; c++) begin
      step(4'b0011);
      chk("hold_b_gnt", gnt, 4'b0010);
      chk("hold_b_pre", preempt, 1'b0);
    end
    step(4'b0011);
    chk("preempt2_gnt", gnt, 4'b0001);
    chk("preempt2_pulse", preempt, 1'b1);

    // Sole requester keeps the grant without preemption.
    for (int c = 0; c < 20; c++) begin
      step(4'b1000);
      chk("sole_gnt", gnt, 4'b1000);
      chk("sole_pre", preempt, 1'b0);
    end

    // Owner 2 releases on its 8th cycle while requester 0 waits.
    step(4'b0000);
    rst_n = 1'b0; model_reset(); #10; rst_n = 1'b1;
    step(4'b0100);
    for (int c = 1; c < MH; c++) begin
      step(4'b0101);
      chk("coinc_hold", gnt, 4'b0100);
    end
    step(4'b0001);
    chk("coinc_gnt", gnt, 4'b0001);
    chk("coinc_pre", preempt, 1'b0);

    // Idle return after a 3-cycle pulse from requester 1.
    for (int c = 0; c < 3; c++) begin
      step(4'b0010);
      chk("pulse_gnt", gnt, 4'b0010);
    end
    step(4'b0000);
    chk("idle_gnt", gnt, 4'b0000);
    chk("idle_valid", gnt_valid, 1'b0);
    // ptr=2 now: scan 2,3,0,1 with req=0011 finds bit 0 first.
    step(4'b0011);
    chk("idle_next_gnt", gnt, 4'b0001);

    // Random traffic; bits toggle occasionally so holds and limits both occur.
    r = 4'b0011;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 199) == 0) r = 4'b0000;
      if ($urandom_range(0, 199) == 0) r = 4'b1111;
      step(r);
    end

    step(4'b0000);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
